// File: rtl/bound_flasher_pkg.sv
// rtl/bound_flasher_pkg.sv - bound flasher state set and per-state sequencing helpers
package bound_flasher_pkg;

    typedef enum logic [3:0] {
        IDLE,
        UP_A,
        DN_A,
        UP_B,
        UP_C,
        DN_B,
        UP_D,
        UP_E,
        UP_F,
        DN_F,
        BLINK
    } state_t;

    typedef struct packed {
        logic        up;
        logic [31:0] target;
    } step_t;

    function automatic step_t step_of(input state_t s, input int n_lamps,
                                      input int b_lo, input int b_hi);
        step_t r;
        r.up     = 1'b0;
        r.target = '0;
        case (s)
            UP_A, UP_B, UP_D: begin r.up = 1'b1; r.target = 32'(b_lo);     end
            UP_C, UP_E:       begin r.up = 1'b1; r.target = 32'(b_hi);     end
            UP_F:             begin r.up = 1'b1; r.target = 32'(n_lamps);  end
            DN_B:             begin r.up = 1'b0; r.target = 32'(b_lo - 1); end
            default:          begin r.up = 1'b0; r.target = '0;            end
        endcase
        return r;
    endfunction

    function automatic logic is_kickback(input state_t s);
        return (s == UP_B) || (s == UP_C) || (s == UP_D) || (s == UP_E);
    endfunction

    function automatic state_t kick_dest(input state_t s);
        return ((s == UP_B) || (s == UP_C)) ? DN_A : DN_B;
    endfunction

    // DN_F is resolved by the top because its successor depends on the build.
    function automatic state_t seq_next(input state_t s);
        state_t r;
        case (s)
            UP_A:    r = DN_A;
            DN_A:    r = UP_B;
            UP_B:    r = UP_C;
            UP_C:    r = DN_B;
            DN_B:    r = UP_D;
            UP_D:    r = UP_E;
            UP_E:    r = UP_F;
            UP_F:    r = DN_F;
            default: r = IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bound_flasher_gen_tick_gen.sv
// rtl/bound_flasher_gen_tick_gen.sv - lamp step prescaler, one tick per TICK_DIV unpaused cycles
module tick_gen #(
    parameter int TICK_DIV = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic pause,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = !clear && !pause && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (!pause) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/bound_flasher_gen.sv
// rtl/bound_flasher_gen.sv - N-lamp fill/drain flasher with kickback; BOUND_FLASHER_BLINK_EN adds a final all-on frame
module bound_flasher_gen
    import bound_flasher_pkg::*;
#(
    parameter int N_LAMPS  = 16,
    parameter int B_LO     = 6,
    parameter int B_HI     = 11,
    parameter int TICK_DIV = 200
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flick,
    input  logic                         pause,
    output logic [N_LAMPS-1:0]           lamps,
    output logic [$clog2(N_LAMPS+1)-1:0] level,
    output logic                         busy
);

    localparam int LW = $clog2(N_LAMPS + 1);
    localparam logic [LW-1:0] ONE = LW'(1);

`ifdef BOUND_FLASHER_BLINK_EN
    localparam state_t FINAL_STATE = BLINK;
`else
    localparam state_t FINAL_STATE = IDLE;
`endif

    state_t        state, state_nx;
    logic [LW-1:0] level_q, level_nx;
    logic          tick;
    logic          idle;
    logic          blinking;
    step_t         step;

    assign idle = (state == IDLE);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(idle),
        .pause(pause),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            level_q <= '0;
        end else begin
            state   <= state_nx;
            level_q <= level_nx;
        end
    end

    // flick only matters on the tick that lands on a kickback state's target.
    always_comb begin
        state_nx = state;
        level_nx = level_q;
        step     = step_of(state, N_LAMPS, B_LO, B_HI);
        case (state)
            IDLE: begin
                level_nx = '0;
                if (flick) state_nx = UP_A;
            end
            BLINK: begin
                if (tick) begin
                    state_nx = IDLE;
                    level_nx = '0;
                end
            end
            default: begin
                if (tick) begin
                    level_nx = step.up ? level_q + ONE : level_q - ONE;
                    if (32'(level_nx) == step.target) begin
                        if (is_kickback(state) && flick) state_nx = kick_dest(state);
                        else if (state == DN_F)          state_nx = FINAL_STATE;
                        else                             state_nx = seq_next(state);
                    end
                end
            end
        endcase
    end

`ifdef BOUND_FLASHER_BLINK_EN
    assign blinking = (state == BLINK);
`else
    assign blinking = 1'b0;
`endif

    assign level = blinking ? LW'(N_LAMPS) : level_q;
    assign busy  = !idle;

    always_comb begin
        lamps = '0;
        for (int i = 0; i < N_LAMPS; i++) begin
            lamps[i] = (i < int'(level));
        end
    end

endmodule

// File: tb/tb_bound_flasher_gen.sv
// tb/tb_bound_flasher_gen.sv - self-checking bench for bound_flasher_gen (honours BOUND_FLASHER_BLINK_EN)
module tb_bound_flasher_gen;

    localparam int N  = 8;
    localparam int LO = 3;
    localparam int HI = 5;
    localparam int TD = 4;
    localparam int LW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flick = 1'b0;
    logic          pause = 1'b0;
    logic [N-1:0]  lamps;
    logic [LW-1:0] level;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    bound_flasher_gen #(
        .N_LAMPS (N),
        .B_LO    (LO),
        .B_HI    (HI),
        .TICK_DIV(TD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .flick(flick),
        .pause(pause),
        .lamps(lamps),
        .level(level),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1..9 the fill/drain segments, 10 the blink frame.
`ifdef BOUND_FLASHER_BLINK_EN
    localparam int FIN = 10;
`else
    localparam int FIN = 0;
`endif
    int tgt[11]  = '{0, LO, 0, LO, HI, LO - 1, LO, HI, N, 0, 0};
    int nxt[11]  = '{0, 2, 3, 4, 5, 6, 7, 8, 9, FIN, 0};
    int kick[11] = '{-1, -1, -1, 2, 2, -1, 5, 5, -1, -1, -1};

    int m_phase = 0;
    int m_level = 0;
    int m_cnt   = 0;

    function automatic int thermo(input int l);
        return (1 << l) - 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_level = 0; m_cnt = 0;
        end else if (m_phase == 0) begin
            if (flick) begin m_phase = 1; m_cnt = 0; end
        end else if (!pause) begin
            if (m_cnt == TD - 1) begin
                m_cnt = 0;
                if (m_phase == 10) begin
                    m_phase = 0; m_level = 0;
                end else begin
                    m_level += (tgt[m_phase] > m_level) ? 1 : -1;
                    if (m_level == tgt[m_phase])
                        m_phase = (kick[m_phase] >= 0 && flick) ? kick[m_phase] : nxt[m_phase];
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    initial begin
        forever begin
            int el;
            @(posedge clk);
            model_step();
            #1;
            el = (m_phase == 10) ? N : m_level;
            chk("model_level", int'(level), el);
            chk("model_lamps", int'(lamps), thermo(el));
            chk("model_busy", int'(busy), int'(m_phase != 0));
        end
    end

    task automatic cyc(input int n, input bit f, input bit p, input bit r);
        repeat (n) begin
            flick = f; pause = p; rst = r;
            @(posedge clk);
            #2;
        end
        flick = 1'b0; pause = 1'b0; rst = 1'b0;
    endtask

    task automatic chk_out(input string name, input int exp_level, input bit exp_busy);
        chk({name, "_level"}, int'(level), exp_level);
        chk({name, "_lamps"}, int'(lamps), thermo(exp_level));
        chk({name, "_busy"}, int'(busy), int'(exp_busy));
    endtask

    typedef struct {
        bit f;
        bit p;
        bit r;
        int cycles;
        int exp_level;
        bit exp_busy;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Full run: edge 0 is the start edge; rows are cumulative edges 0,3,4,12,...
        tbl.push_back('{0, 0, 1, 2, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 0, 1});
        tbl.push_back('{0, 0, 0, 3, 0, 1});
        tbl.push_back('{0, 0, 0, 1, 1, 1});
        tbl.push_back('{0, 0, 0, 8, 3, 1});
        tbl.push_back('{0, 0, 0, 4, 2, 1});
        tbl.push_back('{0, 0, 0, 8, 0, 1});
        tbl.push_back('{0, 0, 0, 12, 3, 1});
        tbl.push_back('{0, 0, 0, 8, 5, 1});
        tbl.push_back('{0, 0, 0, 12, 2, 1});
        tbl.push_back('{0, 0, 0, 4, 3, 1});
        tbl.push_back('{0, 0, 0, 8, 5, 1});
        tbl.push_back('{0, 0, 0, 12, 8, 1});
        tbl.push_back('{0, 0, 0, 28, 1, 1});
        tbl.push_back('{0, 0, 0, 3, 1, 1});
`ifdef BOUND_FLASHER_BLINK_EN
        tbl.push_back('{0, 0, 0, 1, 8, 1});
        tbl.push_back('{0, 0, 0, 3, 8, 1});
        tbl.push_back('{0, 0, 0, 1, 0, 0});
`else
        tbl.push_back('{0, 0, 0, 1, 0, 0});
`endif
        tbl.push_back('{0, 0, 0, 6, 0, 0});

        #2;
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].cycles, tbl[i].f, tbl[i].p, tbl[i].r);
            chk_out($sformatf("table%0d", i), tbl[i].exp_level, tbl[i].exp_busy);
        end

        // Kickback at UP_B reaching LO (edge 36), then reset together with flick at level 4.
        cyc(1, 0, 0, 1);
        cyc(1, 1, 0, 0);
        cyc(35, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk_out("kick_lo_top", 3, 1);
        cyc(4, 0, 0, 0);
        chk_out("kick_lo_down", 2, 1);
        cyc(8, 0, 0, 0);
        chk_out("kick_lo_zero", 0, 1);
        cyc(12, 0, 0, 0);
        chk_out("kick_lo_refill", 3, 1);
        cyc(4, 0, 0, 0);
        chk_out("pre_reset", 4, 1);
        cyc(1, 1, 0, 1);
        chk_out("reset_mid", 0, 0);
        cyc(5, 0, 0, 0);
        chk_out("reset_no_latch", 0, 0);

        // Off-tick flicks in UP_C, then kickback at UP_E, then pause in UP_F.
        cyc(1, 1, 0, 0);
        cyc(37, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(3, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(2, 0, 0, 0);
        chk_out("offtick_top", 5, 1);
        cyc(12, 0, 0, 0);
        chk_out("offtick_drain", 2, 1);
        cyc(11, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk_out("kick_hi_top", 5, 1);
        cyc(12, 0, 0, 0);
        chk_out("kick_hi_drain", 2, 1);
        cyc(12, 0, 0, 0);
        chk_out("kick_hi_refill", 5, 1);
        cyc(5, 0, 0, 0);
        chk_out("pause_before", 6, 1);
        cyc(10, 0, 1, 0);
        chk_out("pause_held", 6, 1);
        cyc(2, 0, 0, 0);
        chk_out("pause_resume_hold", 6, 1);
        cyc(1, 0, 0, 0);
        chk_out("pause_resume_step", 7, 1);
        cyc(4, 0, 0, 0);
        chk_out("pause_full", 8, 1);

        // Random traffic against the reference model.
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            cyc(1, $urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
